cpu_multicycle: RTL and testbench

Parametrised multi-cycle RV32I-subset core: the successor to the single-cycle `cpu` top. It uses one unified memory port with a req/ready handshake that tolerates variable memory latency, and it runs a control FSM instead of single-cycle decode. It owns an internal 32-entry register file and ALU, and exposes `a0` for the testbench and display path. The `trigger` gating is kept, and a `halted` flag is added for illegal instructions.

---
 rtl/cpu_multicycle.sv | 235 +++++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core with a unified req/ready memory port and an 8-state control FSM.
// Define CPU_INSTRET_EN to add the `instret` retired-instruction counter output.
module cpu_multicycle #(
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'hBFC0_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ready,
    output logic [DATA_WIDTH-1:0]    a0,
`ifdef CPU_INSTRET_EN
    output logic [DATA_WIDTH-1:0]    instret,
`endif
    output logic                     halted
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEMADDR, MEMRD, MEMWR, WB, HALT} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]              ir_q, ir_d;
    logic [DATA_WIDTH-1:0]    a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [DATA_WIDTH-1:0]    aluOut_q, aluOut_d, data_q, data_d;
    logic                     fetchPend_q, fetchPend_d;
    logic [DATA_WIDTH-1:0]    regs_q [32];

    logic                     rfWe;
    logic [4:0]               rfAddr;
    logic [DATA_WIDTH-1:0]    rfData;
    logic                     reqInt, weInt;
    logic [ADDRESS_WIDTH-1:0] addrInt;
    logic [DATA_WIDTH-1:0]    wdataInt;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic       isR, isAddi, isLui, isLw, isSw, isBeq, isBne, isJal, isJalr, isLegal;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign isR    = (opcode == 7'b0110011) &&
                    (((funct7 == 7'b0000000) && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                                 funct3 == 3'b110 || funct3 == 3'b010)) ||
                     ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    assign isAddi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign isLui  = (opcode == 7'b0110111);
    assign isLw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign isSw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign isBeq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
    assign isBne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign isJal  = (opcode == 7'b1101111);
    assign isJalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
    assign isLegal = isR | isAddi | isLui | isLw | isSw | isBeq | isBne | isJal | isJalr;

    logic [DATA_WIDTH-1:0] immDec, aluRes, jalrSum;
    logic [ADDRESS_WIDTH-1:0] pcPlus4, pcPlusImm;

    always_comb begin
        immDec = DATA_WIDTH'($signed(ir_q[31:20]));
        if (isSw)
            immDec = DATA_WIDTH'($signed({ir_q[31:25], ir_q[11:7]}));
        else if (isBeq || isBne)
            immDec = DATA_WIDTH'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
        else if (isJal)
            immDec = DATA_WIDTH'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));
        else if (isLui)
            immDec = DATA_WIDTH'($signed({ir_q[31:12], 12'b0}));
    end

    always_comb begin
        aluRes = a_q + imm_q;
        if (isLui) begin
            aluRes = imm_q;
        end else if (isR) begin
            unique case (funct3)
                3'b111:  aluRes = a_q & b_q;
                3'b110:  aluRes = a_q | b_q;
                3'b010:  aluRes = DATA_WIDTH'($signed(a_q) < $signed(b_q));
                default: aluRes = funct7[5] ? (a_q - b_q) : (a_q + b_q);
            endcase
        end
    end

    assign pcPlus4   = pc_q + ADDRESS_WIDTH'(4);
    assign pcPlusImm = pc_q + ADDRESS_WIDTH'($signed(imm_q));
    assign jalrSum   = a_q + imm_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        aluOut_d    = aluOut_q;
        data_d      = data_q;
        fetchPend_d = fetchPend_q;
        rfWe        = 1'b0;
        rfAddr      = rd;
        rfData      = aluOut_q;
        reqInt      = 1'b0;
        weInt       = 1'b0;
        addrInt     = pc_q;
        wdataInt    = '0;
        unique case (state_q)
            FETCH: begin
                // A fetch already issued stays requested even if trigger drops during the wait.
                reqInt      = trigger | fetchPend_q;
                fetchPend_d = reqInt & ~mem_ready;
                if (reqInt && mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d   = regs_q[rs1];
                b_d   = regs_q[rs2];
                imm_d = immDec;
                if (!isLegal)          state_d = HALT;
                else if (isLw || isSw) state_d = MEMADDR;
                else                   state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                if (isJal || isJalr) begin
                    rfWe   = 1'b1;
                    rfData = DATA_WIDTH'(pcPlus4);
                    pc_d   = isJal ? pcPlusImm : ADDRESS_WIDTH'({jalrSum[DATA_WIDTH-1:1], 1'b0});
                end else if (isBeq || isBne) begin
                    pc_d = ((a_q == b_q) ^ isBne) ? pcPlusImm : pcPlus4;
                end else begin
                    aluOut_d = aluRes;
                    state_d  = WB;
                end
            end
            MEMADDR: begin
                aluOut_d = a_q + imm_q;
                state_d  = isLw ? MEMRD : MEMWR;
            end
            MEMRD: begin
                reqInt  = 1'b1;
                addrInt = ADDRESS_WIDTH'(aluOut_q);
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    state_d = WB;
                end
            end
            MEMWR: begin
                reqInt   = 1'b1;
                weInt    = 1'b1;
                addrInt  = ADDRESS_WIDTH'(aluOut_q);
                wdataInt = b_q;
                if (mem_ready) begin
                    pc_d    = pcPlus4;
                    state_d = FETCH;
                end
            end
            WB: begin
                rfWe    = 1'b1;
                rfData  = isLw ? data_q : aluOut_q;
                pc_d    = pcPlus4;
                state_d = FETCH;
            end
            HALT: begin
            end
        endcase
    end

    // Gating with rst drops the request asynchronously and keeps the bus at zero while idle.
    assign mem_req   = rst & reqInt;
    assign mem_we    = mem_req & weInt;
    assign mem_addr  = mem_req ? {addrInt[ADDRESS_WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata = mem_req ? wdataInt : '0;
    assign a0        = regs_q[10];
    assign halted    = (state_q == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            aluOut_q    <= '0;
            data_q      <= '0;
            fetchPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            aluOut_q    <= aluOut_d;
            data_q      <= data_d;
            fetchPend_q <= fetchPend_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rfWe && (rfAddr != 5'd0)) begin
            regs_q[rfAddr] <= rfData;
        end
    end

`ifdef CPU_INSTRET_EN
    logic [DATA_WIDTH-1:0] instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if ((state_q == EXEC || state_q == MEMWR || state_q == WB) && (state_d == FETCH)) begin
            instret_q <= instret_q + DATA_WIDTH'(1);
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed testbench for cpu_multicycle: programs in a word memory model with configurable latency.
// Fetch completions are logged (address and cycle) so PC sequence and per-instruction cycle counts can be checked.
module tb_cpu_multicycle;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, a0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        halted;
`ifdef CPU_INSTRET_EN
    logic [31:0] instret;
`endif

    cpu_multicycle #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .RESET_PC     (RESET_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trigger  (trigger),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .a0       (a0),
`ifdef CPU_INSTRET_EN
        .instret  (instret),
`endif
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int vecCount = 0;
    int errCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    logic [31:0] memWords [256];
    logic [31:0] progQ [$];
    int          memLatency = 0;
    int          waitCnt = 0;
    bit          stableEn = 1'b0;
    logic        heldWe;
    logic [31:0] heldAddr, heldWdata;
    int          fetchN = 0;
    logic [31:0] fetchAddr [16];
    int          fetchCyc [16];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: answers each request after memLatency wait cycles, logs code fetches.
    always @(negedge clk) begin
        if (!rst) begin
            mem_ready = 1'b0;
            waitCnt   = 0;
            fetchN    = 0;
        end else begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                waitCnt   = 0;
            end
            if (mem_req) begin
                if (waitCnt == 0) begin
                    heldWe    = mem_we;
                    heldAddr  = mem_addr;
                    heldWdata = mem_wdata;
                end else if (stableEn) begin
                    checkOutput("stable addr", mem_addr, heldAddr);
                    checkOutput("stable we", {31'b0, mem_we}, {31'b0, heldWe});
                    checkOutput("stable wdata", mem_wdata, heldWdata);
                end
                if (waitCnt >= memLatency) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        memWords[mem_addr[9:2]] = mem_wdata;
                        mem_rdata = 32'h0;
                    end else begin
                        mem_rdata = memWords[mem_addr[9:2]];
                        if (mem_addr[31:28] == 4'hB && fetchN < 16) begin
                            fetchAddr[fetchN] = mem_addr;
                            fetchCyc[fetchN]  = cyc;
                            fetchN++;
                        end
                    end
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    task automatic loadProgram();
        for (int i = 0; i < 256; i++) memWords[i] = 32'h0;
        foreach (progQ[i]) memWords[i] = progQ[i];
    endtask

    task automatic applyReset(input int latency, input logic trig);
        @(posedge clk);
        #1 rst = 1'b0;
        trigger    = trig;
        memLatency = latency;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic applyStimulus(input logic trig);
        @(posedge clk);
        #1 trigger = trig;
    endtask

    task automatic waitFetches(input int n, input int budget);
        int k = 0;
        while (fetchN < n && k < budget) begin
            @(posedge clk);
            #1 k++;
        end
        checkOutput($sformatf("fetch count %0d", n), fetchN, n);
    endtask

    logic [31:0] expOff [8];
    int          expGap [7];
    int          reqSeen;

    initial begin
        // Two addi into a0, then an all-zero word that must halt the core.
        progQ = {32'h0050_0513, 32'hFF95_0513, 32'h0000_0000};
        loadProgram();
        applyReset(0, 1'b1);
        waitFetches(2, 50);
        checkOutput("a0 after addi 5", a0, 32'h0000_0005);
        waitFetches(3, 50);
        checkOutput("a0 after addi -7", a0, 32'hFFFF_FFFE);
        checkOutput("pc after two addi", fetchAddr[2], RESET_PC + 32'd8);
        checkOutput("two ALU ops cycles", fetchCyc[2] - fetchCyc[0], 32'd8);
        checkOutput("halted during decode", {31'b0, halted}, 32'd0);
        @(posedge clk);
        #1 checkOutput("halted after decode", {31'b0, halted}, 32'd1);
        reqSeen = 0;
        repeat (5) begin
            @(negedge clk);
            reqSeen = reqSeen | int'(mem_req);
        end
        checkOutput("no req in halt", reqSeen, 32'd0);
        checkOutput("no fetch in halt", fetchN, 32'd3);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("reset halted", {31'b0, halted}, 32'd0);
        checkOutput("reset a0", a0, 32'd0);
        checkOutput("reset mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("reset mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset mem_wdata", mem_wdata, 32'd0);

        // Store then load through a three-cycle-latency memory.
        progQ = {32'hDEAD_C2B7, 32'hEEF2_8293, 32'h1000_0313, 32'h0053_2023, 32'h0003_2503, 32'h0000_0000};
        loadProgram();
        applyReset(3, 1'b1);
        stableEn = 1'b1;
        waitFetches(6, 200);
        stableEn = 1'b0;
        expGap = '{7, 7, 7, 10, 11, 0, 0};
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("slow gap %0d", i), fetchCyc[i+1] - fetchCyc[i], expGap[i]);
        checkOutput("stored word", memWords[64], 32'hDEAD_BEEF);
        checkOutput("lw into a0", a0, 32'hDEAD_BEEF);

        // Control flow: jal x0, bne backward, jal ra, add a0=ra, jalr with odd target.
        progQ = {32'h0010_0393, 32'h00C0_006F, 32'h0100_00EF, 32'h0140_006F, 32'hFE03_9CE3,
                 32'h0000_0000, 32'h0000_8533, 32'h0010_8067, 32'h0000_0000};
        loadProgram();
        applyReset(0, 1'b1);
        waitFetches(8, 100);
        expOff = '{32'd0, 32'd4, 32'd16, 32'd8, 32'd24, 32'd28, 32'd12, 32'd32};
        expGap = '{4, 3, 3, 3, 4, 3, 3};
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("pc seq %0d", i), fetchAddr[i], RESET_PC + expOff[i]);
        for (int i = 0; i < 7; i++)
            checkOutput($sformatf("flow gap %0d", i), fetchCyc[i+1] - fetchCyc[i], expGap[i]);
        checkOutput("ra via a0", a0, RESET_PC + 32'h0000_000C);

        // Trigger held low, a pulse shorter than the fetch, then reset during a pending fetch.
        progQ = {32'h0050_0513, 32'h0000_0000};
        loadProgram();
        applyReset(2, 1'b0);
        reqSeen = 0;
        repeat (10) begin
            @(negedge clk);
            reqSeen = reqSeen | int'(mem_req);
        end
        checkOutput("idle req", reqSeen, 32'd0);
        applyStimulus(1'b1);
        #1;
        checkOutput("fetch req on trigger", {31'b0, mem_req}, 32'd1);
        checkOutput("fetch addr", mem_addr, RESET_PC);
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("fetch held after drop", {31'b0, mem_req}, 32'd1);
        checkOutput("fetch addr held", mem_addr, RESET_PC);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("stall fetch count", fetchN, 32'd1);
        checkOutput("stall a0", a0, 32'd5);
        checkOutput("stall req", {31'b0, mem_req}, 32'd0);
        applyReset(5, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("pending before reset", {31'b0, mem_req}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("async req drop", {31'b0, mem_req}, 32'd0);

        // ALU mix including slt/sub/and/or and a write to x0.
        progQ = {32'hFFD0_0293, 32'h0050_0313, 32'h0062_A533, 32'h4053_0533, 32'h0062_F533,
                 32'h0062_E533, 32'h0063_0033, 32'h0060_6533, 32'h0000_0000};
        loadProgram();
        applyReset(0, 1'b1);
        waitFetches(4, 50);
        checkOutput("slt", a0, 32'd1);
        waitFetches(5, 50);
        checkOutput("sub", a0, 32'd8);
        waitFetches(6, 50);
        checkOutput("and", a0, 32'd5);
        waitFetches(7, 50);
        checkOutput("or", a0, 32'hFFFF_FFFD);
        waitFetches(9, 50);
        checkOutput("x0 stays zero", a0, 32'd5);
        repeat (2) @(posedge clk);
        #1 checkOutput("alu halt", {31'b0, halted}, 32'd1);
`ifdef CPU_INSTRET_EN
        checkOutput("instret", instret, 32'd8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vecCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
